// File: rtl/conv_row_feeder_if.sv
// Bus between conv_row_feeder and its input RAM, RAM shift register and convolution_fsm.
interface conv_row_feeder_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  sr_wr_en;
    logic [DATA_WIDTH-1:0] sr_wr_data;
    logic                  input_start;
    logic                  shift_row_up;
    logic                  conv_done;

    // Feeder side
    modport master (
        output ram_rd_en, ram_rd_addr, sr_wr_en, sr_wr_data, input_start,
        input  ram_rd_data, shift_row_up, conv_done
    );

    // RAM / shift register / convolution side
    modport slave (
        input  ram_rd_en, ram_rd_addr, sr_wr_en, sr_wr_data, input_start,
        output ram_rd_data, shift_row_up, conv_done
    );
endinterface

// File: rtl/conv_row_feeder.sv
// conv_row_feeder: preloads the RAM shift register with the first image rows,
// starts convolution_fsm, then refills one row per shift_row_up request.
// Optional macro FEEDER_ZERO_PAD_EN: requests past the last image row shift in
// a row of zero words instead of being ignored.
module conv_row_feeder #(
    parameter int unsigned RAM_SR_DEPTH = 4,
    parameter int unsigned NUM_SR_ROWS  = 4,
    parameter int unsigned NUM_IMG_ROWS = 6,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] ram_base_addr,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  overrun,
    conv_row_feeder_if.master     bus
);
    localparam int unsigned COL_W = (RAM_SR_DEPTH > 1) ? $clog2(RAM_SR_DEPTH) : 1;
    localparam int unsigned ROW_W = $clog2(NUM_IMG_ROWS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(RAM_SR_DEPTH - 1);
    localparam logic [ROW_W-1:0] PRE_LAST = ROW_W'(NUM_SR_ROWS - 1);
    localparam logic [ROW_W-1:0] SR_ROWS  = ROW_W'(NUM_SR_ROWS);
    localparam logic [ROW_W-1:0] IMG_ROWS = ROW_W'(NUM_IMG_ROWS);
    localparam logic [DATA_WIDTH-1:0] PAD_WORD = '0;

`ifdef FEEDER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, PRELOAD, START, WAIT_SHIFT, ROW_LOAD, DONE
    } state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] base, base_d;
    logic [ROW_W-1:0]      row, row_d;
    logic [ROW_W-1:0]      rows_loaded, rows_loaded_d;
    logic [COL_W-1:0]      col, col_d;
    logic                  pending, pending_d;
    logic                  done_seen, done_seen_d;
    logic                  overrun_d;
    logic                  pad_mode, pad_mode_d;
    logic                  pad_slot, pad_slot_d;
    logic                  wr_from_ram, wr_from_ram_d;
    logic                  rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic                  wr_en_d;
    logic                  start_d;
    logic                  busy_d;
    logic                  fdone_d;
    logic                  issue;

    // Shift-register data follows the RAM one cycle after the read; pad writes shift zeros
    assign bus.sr_wr_data = (bus.sr_wr_en && wr_from_ram) ? bus.ram_rd_data : PAD_WORD;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state;
        base_d        = base;
        row_d         = row;
        col_d         = col;
        rows_loaded_d = rows_loaded;
        pending_d     = pending;
        done_seen_d   = done_seen;
        overrun_d     = overrun;
        pad_mode_d    = pad_mode;
        pad_slot_d    = 1'b0;
        rd_en_d       = 1'b0;
        rd_addr_d     = bus.ram_rd_addr;
        wr_en_d       = bus.ram_rd_en | pad_slot;
        wr_from_ram_d = bus.ram_rd_en;
        start_d       = 1'b0;
        busy_d        = frame_busy;
        fdone_d       = 1'b0;
        issue         = 1'b0;

        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    base_d        = ram_base_addr;
                    row_d         = '0;
                    col_d         = '0;
                    rows_loaded_d = '0;
                    pending_d     = 1'b0;
                    done_seen_d   = 1'b0;
                    overrun_d     = 1'b0;
                    pad_mode_d    = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = PRELOAD;
                end
            end
            PRELOAD: begin
                issue = 1'b1;
                if (col == COL_LAST) begin
                    col_d = '0;
                    if (row == PRE_LAST) begin
                        rows_loaded_d = SR_ROWS;
                        state_d       = START;
                    end else begin
                        row_d = row + ROW_W'(1);
                    end
                end else begin
                    col_d = col + COL_W'(1);
                end
            end
            START: begin
                if (bus.conv_done) done_seen_d = 1'b1;
                // Final preload word is being written: no read left in flight
                if (!bus.ram_rd_en && bus.sr_wr_en) begin
                    start_d = 1'b1;
                    state_d = WAIT_SHIFT;
                end
            end
            WAIT_SHIFT: begin
                if (done_seen || bus.conv_done) begin
                    done_seen_d = 1'b1;
                    if (!bus.ram_rd_en && !pad_slot && !bus.sr_wr_en) begin
                        fdone_d = 1'b1;
                        state_d = DONE;
                    end
                end else if (bus.shift_row_up || pending) begin
                    pending_d = 1'b0;
                    if (rows_loaded < IMG_ROWS) begin
                        row_d      = rows_loaded;
                        col_d      = '0;
                        pad_mode_d = 1'b0;
                        state_d    = ROW_LOAD;
                    end else if (PAD_EN) begin
                        col_d      = '0;
                        pad_mode_d = 1'b1;
                        state_d    = ROW_LOAD;
                    end
                end
            end
            ROW_LOAD: begin
                issue = 1'b1;
                if (bus.conv_done) done_seen_d = 1'b1;
                if (bus.shift_row_up) begin
                    if (pending) overrun_d = 1'b1;
                    else         pending_d = 1'b1;
                end
                if (col == COL_LAST) begin
                    col_d   = '0;
                    state_d = WAIT_SHIFT;
                    if (!pad_mode) rows_loaded_d = rows_loaded + ROW_W'(1);
                end else begin
                    col_d = col + COL_W'(1);
                end
            end
            DONE: begin
                busy_d      = 1'b0;
                done_seen_d = 1'b0;
                pad_mode_d  = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // One word slot per cycle: a RAM read, or a zero word when padding
        if (issue) begin
            if (pad_mode) begin
                pad_slot_d = 1'b1;
            end else begin
                rd_en_d   = 1'b1;
                rd_addr_d = base + ADDR_WIDTH'(row) * ADDR_WIDTH'(RAM_SR_DEPTH) + ADDR_WIDTH'(col);
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            base            <= '0;
            row             <= '0;
            col             <= '0;
            rows_loaded     <= '0;
            pending         <= 1'b0;
            done_seen       <= 1'b0;
            overrun         <= 1'b0;
            pad_mode        <= 1'b0;
            pad_slot        <= 1'b0;
            wr_from_ram     <= 1'b0;
            bus.ram_rd_en   <= 1'b0;
            bus.ram_rd_addr <= '0;
            bus.sr_wr_en    <= 1'b0;
            bus.input_start <= 1'b0;
            frame_busy      <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            state           <= state_d;
            base            <= base_d;
            row             <= row_d;
            col             <= col_d;
            rows_loaded     <= rows_loaded_d;
            pending         <= pending_d;
            done_seen       <= done_seen_d;
            overrun         <= overrun_d;
            pad_mode        <= pad_mode_d;
            pad_slot        <= pad_slot_d;
            wr_from_ram     <= wr_from_ram_d;
            bus.ram_rd_en   <= rd_en_d;
            bus.ram_rd_addr <= rd_addr_d;
            bus.sr_wr_en    <= wr_en_d;
            bus.input_start <= start_d;
            frame_busy      <= busy_d;
            frame_done      <= fdone_d;
        end
    end
endmodule

// File: tb/tb_conv_row_feeder.sv
// Self-checking bench for conv_row_feeder: RAM model, event logs and a
// row-level reference (frame words are base + k, k counting words loaded).
`timescale 1ns/1ps
module tb_conv_row_feeder;
    localparam int unsigned D   = 4;
    localparam int unsigned SR  = 4;
    localparam int unsigned IMG = 6;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [AW-1:0] ram_base_addr = '0;
    logic          frame_busy, frame_done, overrun;

    conv_row_feeder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    conv_row_feeder #(
        .RAM_SR_DEPTH(D), .NUM_SR_ROWS(SR), .NUM_IMG_ROWS(IMG),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .ram_base_addr(ram_base_addr), .frame_busy(frame_busy),
        .frame_done(frame_done), .overrun(overrun), .bus(bus)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [256];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_addr_q[$], rd_cyc_q[$], wr_data_q[$], wr_cyc_q[$], start_q[$], done_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // RAM: data valid the cycle after the read strobe
    always @(posedge clock) begin
        if (reset) bus.ram_rd_data <= '0;
        else if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    // Event log sampled away from the active edge
    always @(negedge clock) begin
        if (bus.ram_rd_en)   begin rd_addr_q.push_back(int'(bus.ram_rd_addr)); rd_cyc_q.push_back(cyc); end
        if (bus.sr_wr_en)    begin wr_data_q.push_back(int'(bus.sr_wr_data)); wr_cyc_q.push_back(cyc); end
        if (bus.input_start) start_q.push_back(cyc);
        if (frame_done)      done_q.push_back(cyc);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int exp_addr(input int b, input int k);
        return (b + k) % 256;
    endfunction

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete(); wr_data_q.delete();
        wr_cyc_q.delete(); start_q.delete(); done_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_frame(input int b);
        @(negedge clock);
        ram_base_addr = AW'(b);
        frame_start   = 1'b1;
        @(negedge clock);
        frame_start   = 1'b0;
    endtask

    task automatic pulse_shift();
        bus.shift_row_up = 1'b1;
        @(negedge clock);
        bus.shift_row_up = 1'b0;
    endtask

    task automatic pulse_done();
        bus.conv_done = 1'b1;
        @(negedge clock);
        bus.conv_done = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        for (int k = 0; k < budget && start_q.size() == 0; k++) @(negedge clock);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_q.size() == 0; k++) @(negedge clock);
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        reset = 1'b1;
        tick(3);
        obs = {bus.ram_rd_en, bus.ram_rd_addr, bus.sr_wr_en, bus.sr_wr_data,
               bus.input_start, frame_busy, frame_done, overrun};
        total++;
        if (obs !== 22'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_preload();
        int b = 'h10;
        clear_logs();
        start_frame(b);
        total++;
        if (frame_busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", frame_busy); end
        wait_start(60);
        tick(2);
        total++;
        if (rd_addr_q.size() != 16) begin bad++; $display("FAIL preload_reads: got %0d want 16", rd_addr_q.size()); end
        total++;
        if (wr_data_q.size() != 16) begin bad++; $display("FAIL preload_writes: got %0d want 16", wr_data_q.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < rd_addr_q.size() && i < wr_data_q.size()) begin
                total++;
                if (rd_addr_q[i] != exp_addr(b, i)) begin
                    bad++; $display("FAIL preload_addr[%0d]: got %h want %h", i, rd_addr_q[i], exp_addr(b, i));
                end
                total++;
                if (rd_cyc_q[i] != rd_cyc_q[0] + i) begin
                    bad++; $display("FAIL preload_gapless[%0d]: got cyc %0d want %0d", i, rd_cyc_q[i], rd_cyc_q[0] + i);
                end
                total++;
                if (wr_cyc_q[i] != rd_cyc_q[i] + 1 || wr_data_q[i] != int'(mem[exp_addr(b, i)])) begin
                    bad++; $display("FAIL preload_write[%0d]: got cyc %0d data %h want cyc %0d data %h",
                                    i, wr_cyc_q[i], wr_data_q[i], rd_cyc_q[i] + 1, mem[exp_addr(b, i)]);
                end
            end
        end
        total++;
        if (start_q.size() != 1) begin bad++; $display("FAIL input_start_count: got %0d want 1", start_q.size()); end
        else if (wr_cyc_q.size() > 0) begin
            total++;
            if (start_q[0] != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
                bad++; $display("FAIL input_start_time: got %0d want %0d", start_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
            end
        end
    endtask

    task automatic test_refill();
        int b = 'h10;
        int exp_wr;
        clear_logs();
        @(negedge clock);
        pulse_shift();
        tick(3);
        pulse_shift();
        tick(15);
        total++;
        if (rd_addr_q.size() != 8) begin bad++; $display("FAIL refill_reads: got %0d want 8", rd_addr_q.size()); end
        for (int i = 0; i < 8 && i < rd_addr_q.size() && i < wr_data_q.size(); i++) begin
            total++;
            if (rd_addr_q[i] != exp_addr(b, 16 + i) || wr_data_q[i] != int'(mem[exp_addr(b, 16 + i)])) begin
                bad++; $display("FAIL refill_word[%0d]: got addr %h data %h want addr %h data %h", i,
                                rd_addr_q[i], wr_data_q[i], exp_addr(b, 16 + i), mem[exp_addr(b, 16 + i)]);
            end
        end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL refill_overrun: got %b want 0", overrun); end
        clear_logs();
        pulse_shift();
        tick(12);
`ifdef FEEDER_ZERO_PAD_EN
        exp_wr = 4;
`else
        exp_wr = 0;
`endif
        total++;
        if (rd_addr_q.size() != 0 || wr_data_q.size() != exp_wr) begin
            bad++; $display("FAIL exhausted_rows: got reads %0d writes %0d want reads 0 writes %0d",
                            rd_addr_q.size(), wr_data_q.size(), exp_wr);
        end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            total++;
            if (wr_data_q[i] != 0) begin bad++; $display("FAIL pad_data[%0d]: got %h want 0", i, wr_data_q[i]); end
        end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL exhausted_overrun: got %b want 0", overrun); end
        pulse_done();
        wait_done(30);
        tick(2);
        total++;
        if (done_q.size() != 1 || frame_busy !== 1'b0) begin
            bad++; $display("FAIL refill_finish: got done %0d busy %b want done 1 busy 0", done_q.size(), frame_busy);
        end
    endtask

    task automatic test_overrun();
        int b = int'($urandom_range(0, 255));
        clear_logs();
        start_frame(b);
        wait_start(60);
        tick(2);
        clear_logs();
        pulse_shift();
        @(negedge clock);
        pulse_shift();
        pulse_shift();
        tick(15);
        total++;
        if (rd_addr_q.size() != 8) begin bad++; $display("FAIL overrun_reads: got %0d want 8", rd_addr_q.size()); end
        for (int i = 0; i < 8 && i < rd_addr_q.size(); i++) begin
            total++;
            if (rd_addr_q[i] != exp_addr(b, 16 + i)) begin
                bad++; $display("FAIL overrun_addr[%0d]: got %h want %h", i, rd_addr_q[i], exp_addr(b, 16 + i));
            end
        end
        if (rd_cyc_q.size() == 8) begin
            total++;
            if (rd_cyc_q[4] - rd_cyc_q[3] > 3) begin
                bad++; $display("FAIL pending_latency: got gap %0d want <= 3", rd_cyc_q[4] - rd_cyc_q[3]);
            end
        end
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
        pulse_done();
        wait_done(30);
        tick(3);
        total++;
        if (overrun !== 1'b1 || frame_busy !== 1'b0) begin
            bad++; $display("FAIL overrun_sticky: got overrun %b busy %b want 1 0", overrun, frame_busy);
        end
    endtask

    task automatic test_completion();
        int b = int'($urandom_range(0, 255));
        clear_logs();
        start_frame(b);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
        wait_start(60);
        tick(2);
        clear_logs();
        start_frame((b + 'h55) % 256);
        pulse_shift();
        @(negedge clock);
        pulse_done();
        wait_done(30);
        tick(3);
        total++;
        if (rd_addr_q.size() != 4 || wr_data_q.size() != 4) begin
            bad++; $display("FAIL done_midload: got reads %0d writes %0d want 4 4", rd_addr_q.size(), wr_data_q.size());
        end
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
            total++;
            if (rd_addr_q[i] != exp_addr(b, 16 + i)) begin
                bad++; $display("FAIL busy_ignore_addr[%0d]: got %h want %h", i, rd_addr_q[i], exp_addr(b, 16 + i));
            end
        end
        total++;
        if (done_q.size() != 1) begin bad++; $display("FAIL frame_done_pulse: got %0d cycles want 1", done_q.size()); end
        else if (wr_cyc_q.size() > 0) begin
            total++;
            if (done_q[0] <= wr_cyc_q[wr_cyc_q.size()-1]) begin
                bad++; $display("FAIL done_after_write: got %0d want > %0d", done_q[0], wr_cyc_q[wr_cyc_q.size()-1]);
            end
        end
        total++;
        if (frame_busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL idle_after_done: got busy %b done %b want 0 0", frame_busy, frame_done);
        end
    endtask

    task automatic test_wrap_reset();
        logic [21:0] obs;
        clear_logs();
        start_frame('hFA);
        wait_start(60);
        tick(2);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= rd_addr_q.size() || rd_addr_q[i] != exp_addr('hFA, i)) begin
                bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i,
                                (i < rd_addr_q.size()) ? rd_addr_q[i] : -1, exp_addr('hFA, i));
            end
        end
        pulse_done();
        wait_done(30);
        tick(2);
        start_frame('h33);
        tick(5);
        reset = 1'b1;
        @(negedge clock);
        obs = {bus.ram_rd_en, bus.ram_rd_addr, bus.sr_wr_en, bus.sr_wr_data,
               bus.input_start, frame_busy, frame_done, overrun};
        total++;
        if (obs !== 22'd0) begin bad++; $display("FAIL reset_midframe: got %h want 0", obs); end
        reset = 1'b0;
        clear_logs();
        tick(8);
        total++;
        if (rd_addr_q.size() != 0 || wr_data_q.size() != 0) begin
            bad++; $display("FAIL reset_abort: got reads %0d writes %0d want 0 0", rd_addr_q.size(), wr_data_q.size());
        end
        start_frame('h40);
        wait_start(60);
        tick(2);
        total++;
        if (rd_addr_q.size() != 16 || rd_addr_q[0] != 'h40 || rd_addr_q[15] != 'h4F) begin
            bad++; $display("FAIL restart_preload: got %0d reads want 16 from 40..4f", rd_addr_q.size());
        end
        pulse_done();
        wait_done(30);
        tick(2);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int b = int'($urandom_range(0, 255));
            int nshift = int'($urandom_range(1, 4));
            int rows, nwords;
            clear_logs();
            start_frame(b);
            wait_start(60);
            for (int s = 0; s < nshift; s++) begin
                tick(int'($urandom_range(7, 12)));
                pulse_shift();
            end
            tick(int'($urandom_range(7, 10)));
            pulse_done();
            wait_done(30);
            tick(2);
            rows   = (SR + nshift > IMG) ? IMG : SR + nshift;
            nwords = rows * D;
            total++;
            if (rd_addr_q.size() != nwords || wr_data_q.size() != nwords) begin
                bad++; $display("FAIL rand_count[%0d]: got reads %0d writes %0d want %0d",
                                it, rd_addr_q.size(), wr_data_q.size(), nwords);
            end
            for (int k = 0; k < nwords && k < rd_addr_q.size() && k < wr_data_q.size(); k++) begin
                total++;
                if (rd_addr_q[k] != exp_addr(b, k) || wr_data_q[k] != int'(mem[exp_addr(b, k)])) begin
                    bad++; $display("FAIL rand_word[%0d][%0d]: got addr %h data %h want addr %h data %h", it, k,
                                    rd_addr_q[k], wr_data_q[k], exp_addr(b, k), mem[exp_addr(b, k)]);
                end
            end
            total++;
            if (start_q.size() != 1 || done_q.size() != 1 || overrun !== 1'b0) begin
                bad++; $display("FAIL rand_frame[%0d]: got start %0d done %0d overrun %b want 1 1 0",
                                it, start_q.size(), done_q.size(), overrun);
            end
        end
    endtask

    initial begin
        bus.shift_row_up = 1'b0;
        bus.conv_done    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_preload();
        test_refill();
        test_overrun();
        test_completion();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_row_feeder.md
Name: conv_row_feeder

Overview:
- Upstream companion of convolution_fsm. Owns the producer side of the input_start / shift_row_up / conv_done handshake.
- Preloads the first NUM_SR_ROWS image rows from input RAM into the RAM shift register, then pulses input_start.
- Refills one row per shift_row_up request and reports frame completion once conv_done arrives.

Parameters:
RAM_SR_DEPTH, 4, words per shift-register row (reads per row load)
NUM_SR_ROWS, 4, rows preloaded before input_start
NUM_IMG_ROWS, 6, total image rows per frame (must be >= NUM_SR_ROWS)
ADDR_WIDTH, 8, input RAM address width
DATA_WIDTH, 8, pixel word width

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
frame_start  input  1  one-cycle pulse, begins a frame; ignored unless IDLE
ram_base_addr  input  ADDR_WIDTH  frame base address, sampled on accepted frame_start
ram_rd_en  output  1  RAM read strobe
ram_rd_addr  output  ADDR_WIDTH  RAM read address
ram_rd_data  input  DATA_WIDTH  RAM data, valid exactly 1 cycle after ram_rd_en
sr_wr_en  output  1  shift one word into RAM shift register
sr_wr_data  output  DATA_WIDTH  word to shift in
input_start  output  1  one-cycle pulse to convolution_fsm
shift_row_up  input  1  row-refill request from convolution_fsm
conv_done  input  1  convolution complete pulse
frame_busy  output  1  high from accepted frame_start through DONE
frame_done  output  1  one-cycle completion pulse
overrun  output  1  sticky error flag; cleared by reset or accepted frame_start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, pending and done latches cleared. Reset mid-frame aborts immediately; no further RAM reads or SR writes.
- States: IDLE, PRELOAD, START, WAIT_SHIFT, ROW_LOAD, DONE.
- IDLE:
  - On frame_start, latch ram_base_addr, row=0, col=0, and go to PRELOAD.
  - frame_busy rises the cycle after frame_start.
- Read address: ram_rd_addr = base + row*RAM_SR_DEPTH + col, computed modulo 2^ADDR_WIDTH (wraps, no error).
- Read/write pipeline: sr_wr_en is ram_rd_en delayed 1 cycle; sr_wr_data = ram_rd_data. Reads are back-to-back, one per cycle, with no gaps.
- PRELOAD:
  - Issue NUM_SR_ROWS*RAM_SR_DEPTH consecutive reads, then go to START.
  - START waits for the final sr_wr_en, then asserts input_start for exactly 1 cycle, then goes to WAIT_SHIFT.
  - rows_loaded = NUM_SR_ROWS.
- WAIT_SHIFT:
  - On shift_row_up (or pending set) with rows_loaded < NUM_IMG_ROWS: clear pending, go to ROW_LOAD.
  - ROW_LOAD issues RAM_SR_DEPTH reads for row rows_loaded, increments rows_loaded, and returns to WAIT_SHIFT after its last read.
- Pending request:
  - shift_row_up arriving during ROW_LOAD sets a 1-deep pending bit.
  - shift_row_up while pending is already set sets overrun; the request is dropped.
  - shift_row_up on the last cycle of ROW_LOAD sets pending; it is not counted as overrun.
- Rows exhausted: shift_row_up with rows_loaded == NUM_IMG_ROWS does no reads (see Optional Feature).
- conv_done:
  - Latched in any state from START through ROW_LOAD.
  - An in-progress ROW_LOAD always completes, including its trailing SR write.
  - When the latch is set and no load or write is outstanding, go to DONE.
- DONE: frame_done is high for 1 cycle, then IDLE; frame_busy falls with the return to IDLE.
- conv_done in IDLE is ignored. Simultaneous conv_done and shift_row_up in WAIT_SHIFT: conv_done wins, no load.

Optional Feature:
- Macro: FEEDER_ZERO_PAD_EN.
- When defined: each shift_row_up after rows_loaded == NUM_IMG_ROWS produces RAM_SR_DEPTH consecutive sr_wr_en cycles with sr_wr_data = 0, with no ram_rd_en. Timing and pending/overrun rules are identical to ROW_LOAD (bottom zero padding).
- When undefined: such requests are ignored; no writes, no overrun.

Test Plan:
- Preload, base=0x10, defaults: frame_start -> ram_rd_en 16 consecutive cycles on addrs 0x10..0x1F; sr_wr_en 16 cycles lagging by 1 with matching data; input_start a single pulse one cycle after the last sr_wr_en.
- Refill: two shift_row_up pulses 4 cycles apart -> reads 0x20..0x23, then 0x24..0x27; overrun stays 0. A third shift_row_up -> no reads, no writes (FEEDER_ZERO_PAD_EN undefined).
- Overrun: during ROW_LOAD, pulse shift_row_up twice -> pending serviced immediately after the load; overrun=1 and stays 1 until the next frame_start.
- Completion: conv_done asserted mid-ROW_LOAD -> all 4 writes complete, then frame_done one 1-cycle pulse; frame_busy drops. frame_start during busy -> ignored.
- Wrap and reset: base=0xFA -> preload addresses 0xFA..0xFF then 0x00..0x09. reset asserted mid-PRELOAD -> next cycle all outputs 0; a fresh frame_start restarts from base.
- With FEEDER_ZERO_PAD_EN defined: a shift_row_up after row 6 -> 4 sr_wr_en cycles with data 0 and no ram_rd_en.
